// File: rtl/reg_file_2r1w.sv
// Two-read / one-write register file with registered read ports.
// Reads see the write performed on the same edge (write-to-read bypass).

// One read port: selects the post-write value of raddr and holds it on rdata
// until the next accepted read.
module reg_file_2r1w_rd #(
  parameter int N        = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  localparam int DEPTH   = 2**ADDR_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       re,
  input  logic [ADDR_W-1:0]          raddr,
  input  logic                       we,
  input  logic [ADDR_W-1:0]          waddr,
  input  logic [N-1:0]               wdata,
  input  logic [DEPTH-1:0][N-1:0]    regs,
  output logic [N-1:0]               rdata
);

  logic [N-1:0] rd_nxt;

  // post-write view of raddr: bypass the in-flight write, r0 forced to zero
  always_comb begin
    rd_nxt = regs[raddr];
    if (we && (waddr == raddr)) rd_nxt = wdata;
    if ((ZERO_REG != 0) && (raddr == '0)) rd_nxt = '0;
  end

  // capture on read, hold otherwise
  always_ff @(posedge clk) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= rd_nxt;
  end

endmodule

module reg_file_2r1w #(
  parameter int N        = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [N-1:0]      wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [N-1:0]      rdata1,
  output logic [N-1:0]      rdata2,
  output logic              rvalid
);

  localparam int DEPTH    = 2**ADDR_W;
  localparam int NUM_RD   = 2;
  localparam int STAGES   = 1;

  logic [DEPTH-1:0][N-1:0]       regs;
  logic [NUM_RD-1:0][ADDR_W-1:0] raddr_v;
  logic [NUM_RD-1:0][N-1:0]      rdata_v;
  logic [STAGES:0]               vld_pipe;
  logic                          wr_ok;

  assign raddr_v = {raddr2, raddr1};
  assign rdata1  = rdata_v[0];
  assign rdata2  = rdata_v[1];

  // writes to r0 are dropped when it is hardwired
  assign wr_ok = we && !((ZERO_REG != 0) && (waddr == '0));

  // storage: clear on reset, single write port
  always_ff @(posedge clk) begin
    if (reset)      regs <= '0;
    else if (wr_ok) regs[waddr] <= wdata;
  end

  genvar p;
  generate
    for (p = 0; p < NUM_RD; p++) begin : g_rd
      reg_file_2r1w_rd #(.N(N), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_rd (
        .clk   (clk),
        .reset (reset),
        .re    (re),
        .raddr (raddr_v[p]),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .regs  (regs),
        .rdata (rdata_v[p])
      );
    end
  endgenerate

  // read-valid pipe; a reset edge kills any request on that edge
  assign vld_pipe[0] = re && !reset;
  always_ff @(posedge clk) begin
    if (reset) vld_pipe[STAGES:1] <= '0;
    else       vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
  end

  assign rvalid = vld_pipe[STAGES];

endmodule

// File: tb/tb_reg_file_2r1w.sv
module tb_reg_file_2r1w;

  logic        clk = 1'b0;
  logic        reset, we, re;
  logic [4:0]  waddr, raddr1, raddr2;
  logic [31:0] wdata;
  logic [31:0] z_rd1, z_rd2, o_rd1, o_rd2;
  logic        z_rv, o_rv;

  int n_chk = 0;
  int n_fail = 0;

  // behavioural model: two register arrays, one per ZERO_REG flavour
  logic [31:0] mz [32];
  logic [31:0] mo [32];
  logic [31:0] ez1, ez2, eo1, eo2;
  logic        ev;

  always #5 clk = ~clk;

  reg_file_2r1w #(.N(32), .ADDR_W(5), .ZERO_REG(1)) dut_z (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata), .re(re),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(z_rd1), .rdata2(z_rd2), .rvalid(z_rv));

  reg_file_2r1w #(.N(32), .ADDR_W(5), .ZERO_REG(0)) dut_o (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata), .re(re),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(o_rd1), .rdata2(o_rd2), .rvalid(o_rv));

  // apply one clock edge's worth of effect to the model
  task automatic model_edge();
    if (reset) begin
      for (int i = 0; i < 32; i++) begin mz[i] = '0; mo[i] = '0; end
      ez1 = '0; ez2 = '0; eo1 = '0; eo2 = '0; ev = 1'b0;
    end else begin
      if (we) begin
        mo[waddr] = wdata;
        if (waddr != 0) mz[waddr] = wdata;
      end
      ev = re;
      if (re) begin
        ez1 = (raddr1 == 0) ? 32'h0 : mz[raddr1];
        ez2 = (raddr2 == 0) ? 32'h0 : mz[raddr2];
        eo1 = mo[raddr1];
        eo2 = mo[raddr2];
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    reset = 0; we = 0; re = 0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;
  endtask

  task automatic test_reset();
    idle(); reset = 1;
    tick(); tick();
    n_chk++;
    if ({z_rv, z_rd1, z_rd2} !== 65'h0 || {o_rv, o_rd1, o_rd2} !== 65'h0) begin
      n_fail++; $display("FAIL reset_state: z=%0b/%h/%h o=%0b/%h/%h want 0/0/0", z_rv, z_rd1, z_rd2, o_rv, o_rd1, o_rd2);
    end
    idle(); re = 1; raddr1 = 7; raddr2 = 31;
    tick();
    n_chk++;
    if ({z_rv, z_rd1, z_rd2} !== {1'b1, 64'h0} || {o_rv, o_rd1, o_rd2} !== {1'b1, 64'h0}) begin
      n_fail++; $display("FAIL first_read: z=%0b/%h/%h o=%0b/%h/%h want 1/0/0", z_rv, z_rd1, z_rd2, o_rv, o_rd1, o_rd2);
    end
  endtask

  task automatic test_write_read();
    idle(); we = 1; waddr = 5; wdata = 32'hDEADBEEF;
    tick();
    n_chk++;
    if (z_rv !== 1'b0 || o_rv !== 1'b0) begin
      n_fail++; $display("FAIL no_read_rvalid: z=%0b o=%0b want 0", z_rv, o_rv);
    end
    idle(); re = 1; raddr1 = 5; raddr2 = 7;
    tick();
    n_chk++;
    if (z_rv !== 1'b1 || z_rd1 !== 32'hDEADBEEF || o_rd1 !== 32'hDEADBEEF || z_rd2 !== 32'h0) begin
      n_fail++; $display("FAIL write_read: rv=%0b z_rd1=%h o_rd1=%h z_rd2=%h want 1/deadbeef/deadbeef/0", z_rv, z_rd1, o_rd1, z_rd2);
    end
  endtask

  task automatic test_bypass();
    idle(); we = 1; waddr = 9; wdata = 32'h12345678; re = 1; raddr1 = 9; raddr2 = 9;
    tick();
    n_chk++;
    if (z_rd1 !== 32'h12345678 || z_rd2 !== 32'h12345678 || o_rd1 !== 32'h12345678 ||
        o_rd2 !== 32'h12345678 || z_rv !== 1'b1) begin
      n_fail++; $display("FAIL bypass: z=%h/%h o=%h/%h rv=%0b want 12345678 x4 rv=1", z_rd1, z_rd2, o_rd1, o_rd2, z_rv);
    end
  endtask

  task automatic test_zero_reg();
    idle(); we = 1; waddr = 0; wdata = 32'hFFFFFFFF; re = 1; raddr1 = 0; raddr2 = 9;
    tick();
    n_chk++;
    if (z_rd1 !== 32'h0 || o_rd1 !== 32'hFFFFFFFF) begin
      n_fail++; $display("FAIL zero_same_edge: z_rd1=%h o_rd1=%h want 0/ffffffff", z_rd1, o_rd1);
    end
    idle(); re = 1; raddr1 = 0; raddr2 = 0;
    tick();
    n_chk++;
    if (z_rd1 !== 32'h0 || z_rd2 !== 32'h0 || o_rd1 !== 32'hFFFFFFFF || o_rd2 !== 32'hFFFFFFFF) begin
      n_fail++; $display("FAIL zero_next_edge: z=%h/%h o=%h/%h want 0/0 ffffffff/ffffffff", z_rd1, z_rd2, o_rd1, o_rd2);
    end
  endtask

  task automatic test_hold();
    idle(); re = 1; raddr1 = 5; raddr2 = 9;
    tick();
    idle(); we = 1; waddr = 5; wdata = 32'h0BADF00D;
    tick();
    waddr = 9; wdata = 32'hCAFEF00D;
    tick();
    n_chk++;
    if (z_rv !== 1'b0 || z_rd1 !== 32'hDEADBEEF || z_rd2 !== 32'h12345678 || o_rd1 !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL hold: rv=%0b z=%h/%h o_rd1=%h want 0 deadbeef/12345678 deadbeef", z_rv, z_rd1, z_rd2, o_rd1);
    end
  endtask

  task automatic test_back_to_back();
    idle(); we = 1;
    for (int a = 0; a < 32; a++) begin
      waddr = a[4:0]; wdata = a * 32'h01010101;
      tick();
    end
    idle(); re = 1;
    for (int a = 0; a < 32; a++) begin
      raddr1 = a[4:0]; raddr2 = 5'(31 - a);
      tick();
      n_chk++;
      if (z_rv !== 1'b1 || o_rv !== 1'b1 ||
          z_rd1 !== a * 32'h01010101 || z_rd2 !== (31 - a) * 32'h01010101 ||
          o_rd1 !== a * 32'h01010101 || o_rd2 !== (31 - a) * 32'h01010101) begin
        n_fail++; $display("FAIL b2b[%0d]: rv=%0b/%0b z=%h/%h o=%h/%h want %h/%h", a, z_rv, o_rv,
                           z_rd1, z_rd2, o_rd1, o_rd2, a * 32'h01010101, (31 - a) * 32'h01010101);
      end
    end
    idle();
    tick();
    n_chk++;
    if (z_rv !== 1'b0) begin
      n_fail++; $display("FAIL b2b_end: rvalid=%0b want 0", z_rv);
    end
  endtask

  task automatic test_reset_mid();
    idle(); we = 1; waddr = 3; wdata = 32'hA5A5A5A5;
    tick();
    idle(); reset = 1; re = 1; raddr1 = 3; we = 1; waddr = 4; wdata = 32'h11111111;
    tick();
    n_chk++;
    if (z_rv !== 1'b0 || o_rv !== 1'b0 || z_rd1 !== 32'h0) begin
      n_fail++; $display("FAIL reset_cancel: rv=%0b/%0b rd1=%h want 0/0/0", z_rv, o_rv, z_rd1);
    end
    idle(); re = 1; raddr1 = 3; raddr2 = 4;
    tick();
    n_chk++;
    if (z_rv !== 1'b1 || z_rd1 !== 32'h0 || z_rd2 !== 32'h0 || o_rd1 !== 32'h0 || o_rd2 !== 32'h0) begin
      n_fail++; $display("FAIL reset_cleared: rv=%0b z=%h/%h o=%h/%h want 1 and zeros", z_rv, z_rd1, z_rd2, o_rd1, o_rd2);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset  = ($urandom_range(0, 31) == 0);
      we     = $urandom_range(0, 1);
      re     = ($urandom_range(0, 3) != 0);
      waddr  = 5'($urandom_range(0, 31));
      raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      raddr2 = ($urandom_range(0, 3) == 0) ? raddr1 : 5'($urandom_range(0, 31));
      wdata  = $urandom;
      tick();
      n_chk++;
      if ({z_rv, z_rd1, z_rd2} !== {ev, ez1, ez2}) begin
        n_fail++; $display("FAIL rand_z[%0d]: got %0b/%h/%h want %0b/%h/%h", i, z_rv, z_rd1, z_rd2, ev, ez1, ez2);
      end
      n_chk++;
      if ({o_rv, o_rd1, o_rd2} !== {ev, eo1, eo2}) begin
        n_fail++; $display("FAIL rand_o[%0d]: got %0b/%h/%h want %0b/%h/%h", i, o_rv, o_rd1, o_rd2, ev, eo1, eo2);
      end
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_write_read();
    test_bypass();
    test_zero_reg();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_2r1w.md
REG_FILE_2R1W -- requirements
Module: reg_file_2r1w

Interface
REQ-001 Parameter N, default 32: data width of every register in bits.
REQ-002 Parameter ADDR_W, default 5: address width; register count DEPTH = 2**ADDR_W.
REQ-003 Parameter ZERO_REG, default 1: 1 = register 0 is hardwired to zero; 0 = register 0 is an ordinary register.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  input  1  system clock; all state updates on the rising edge.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 we  input  1  write enable.
REQ-008 waddr  input  ADDR_W  write address.
REQ-009 wdata  input  N  write data.
REQ-010 re  input  1  read request; samples both read addresses.
REQ-011 raddr1  input  ADDR_W  read port 1 address.
REQ-012 raddr2  input  ADDR_W  read port 2 address.
REQ-013 rdata1  output  N  registered read data, port 1.
REQ-014 rdata2  output  N  registered read data, port 2.
REQ-015 rvalid  output  1  high for exactly one cycle when rdata1/rdata2 carry fresh data.

Function
REQ-016 Storage SHALL be DEPTH registers of N bits each.
REQ-017 Write: on a rising edge with we=1 and reset=0, reg[waddr] SHALL take wdata.
REQ-018 Write to address 0 when ZERO_REG=1 SHALL be discarded; reg[0] SHALL always read 0.
REQ-019 Read latency SHALL be 1 cycle: re=1 at edge k -> rdata1/rdata2 updated and rvalid=1 after edge k.
REQ-020 rdata1 SHALL equal the content of raddr1 as seen after the write at the same edge; likewise rdata2 for raddr2.
REQ-021 Bypass: if we=1, re=1 and waddr equals raddr1 (or raddr2) at the same edge, that port SHALL return wdata, except address 0 with ZERO_REG=1, which SHALL return 0.
REQ-022 Both read ports SHALL be independent; raddr1=raddr2 SHALL return identical data on both ports.
REQ-023 With re=0 at an edge, rvalid SHALL be 0 after that edge and rdata1/rdata2 SHALL hold their previous values.
REQ-024 Back-to-back reads (re=1 on consecutive edges) SHALL produce rvalid=1 on consecutive cycles, one result per request, no bubbles.
REQ-025 Writes to an address already latched onto rdata SHALL NOT alter the held rdata until the next read.
REQ-026 No address is out of range; all 2**ADDR_W addresses SHALL be writable and readable.

Reset
REQ-027 On an edge with reset=1, all registers, rdata1, rdata2 SHALL become 0 and rvalid SHALL become 0.
REQ-028 reset SHALL take priority over we and re at the same edge; the write and read SHALL be discarded.
REQ-029 Reset asserted mid-stream SHALL cancel any read in flight; no rvalid pulse SHALL follow the reset edge.
REQ-030 The first edge with reset=0 SHALL accept writes and reads normally.

Verification
REQ-031 Reset then re=1, raddr1=7, raddr2=31 -> rvalid=1, rdata1=0, rdata2=0 one cycle later.
REQ-032 we=1, waddr=5, wdata=0xDEADBEEF; next edge re=1, raddr1=5 -> rdata1=0xDEADBEEF, rvalid=1.
REQ-033 Same edge we=1, waddr=9, wdata=0x12345678, re=1, raddr1=9, raddr2=9 -> both ports 0x12345678 (bypass).
REQ-034 ZERO_REG=1: we=1, waddr=0, wdata=0xFFFFFFFF, re=1, raddr1=0 same edge and next edge -> rdata1=0 both times; ZERO_REG=0 -> 0xFFFFFFFF both times.
REQ-035 Write all 32 registers with value = address*0x01010101, then 32 back-to-back reads on both ports (raddr2 = 31-raddr1) -> 32 consecutive rvalid pulses with matching data.
REQ-036 Write reg 3 = 0xA5A5A5A5, assert reset together with re=1, raddr1=3 -> rvalid stays 0, then a read of reg 3 returns 0.
